// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounced input synchroniser.
package debounce_pkg;

   typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} db_state_t;

   function automatic int cnt_width(input int stable_cycles);
      return $clog2(stable_cycles);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin; both flops reset to INIT.
module sync_2ff #(
   parameter logic INIT = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1;
   logic s2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= INIT;
         s2 <= INIT;
      end else begin
         s1 <= d;
         s2 <= s1;
      end
   end

   assign q = s2;

endmodule

// File: rtl/debounce_sync.sv
// Debounced synchroniser: 2-flop sync followed by a stability-qualified level FSM
// with registered one-cycle rise/fall strobes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LOW       | output stable at 0
// WAIT_HIGH | output 0, synchronised input 1, counting stable edges
// HIGH      | output stable at 1
// WAIT_LOW  | output 1, synchronised input 0, counting stable edges
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int   STABLE_CYCLES = 500000,
   parameter logic INIT_LEVEL    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic in_async,
   output logic out_level,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int             CNT_W    = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             in_s;
   db_state_t        state;
   logic [CNT_W-1:0] cnt;

   sync_2ff #(.INIT(INIT_LEVEL)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (in_async),
      .q     (in_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= INIT_LEVEL ? HIGH : LOW;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            LOW: begin
               if (in_s) begin
                  state <= WAIT_HIGH;
                  cnt   <= CNT_W'(1);
               end else begin
                  cnt <= '0;
               end
            end
            HIGH: begin
               if (!in_s) begin
                  state <= WAIT_LOW;
                  cnt   <= CNT_W'(1);
               end else begin
                  cnt <= '0;
               end
            end
            WAIT_HIGH: begin
               // Any return to the old level throws away the partial count.
               if (!in_s) begin
                  state <= LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= HIGH;
                  cnt   <= '0;
                  rise  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT_LOW: begin
               if (in_s) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= LOW;
                  cnt   <= '0;
                  fall  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign out_level = (state == HIGH) || (state == WAIT_LOW);
   assign busy      = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule
